// File: rtl/timer_bank_pkg.sv
// Register map and CTRL/STATUS bit positions shared by the timer bank and its channels.
package timer_bank_pkg;

    // Global block, word offsets within the first 16-byte slot
    localparam logic [3:0] OFF_COUNT    = 4'h0;
    localparam logic [3:0] OFF_PRESCALE = 4'h4;

    // Channel i lives at CH_BASE + i*CH_STRIDE
    localparam int unsigned CH_BASE   = 16;
    localparam int unsigned CH_STRIDE = 16;

    localparam logic [3:0] OFF_CMP    = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_PERIOD = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_W          = 3;
    localparam int EN_BIT          = 0;
    localparam int PER_BIT         = 1;
    localparam int IE_BIT          = 2;
    localparam int STATUS_PEND_BIT = 0;

endpackage

// File: rtl/timer_bank_channel.sv
// One compare channel: CMP, CTRL, PERIOD and the pending flag, matched against the shared COUNT.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              tick_i,
    input  logic              we_cmp_i,
    input  logic              we_ctrl_i,
    input  logic              we_period_i,
    input  logic              we_status_i,
    input  logic [CNT_W-1:0]  wdata_i,
    output logic [CNT_W-1:0]  cmp_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  period_o,
    output logic              pend_o,
    output logic              irq_bit_o
);

    logic [CNT_W-1:0]  cmp_q, cmp_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              pend_q, pend_d;
    logic              match;

    // Uses the registered en, so enabling on the matching cycle does not fire.
    assign match = tick_i && ctrl_q[EN_BIT] && (count_i == cmp_q);

    // CPU writes override the match update for CMP/CTRL; for pending the match beats W1C.
    always_comb begin
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        pend_d   = pend_q;
        if (match) begin
            if (ctrl_q[PER_BIT]) cmp_d = cmp_q + period_q;
            else                 ctrl_d[EN_BIT] = 1'b0;
        end
        if (we_cmp_i)    cmp_d    = wdata_i;
        if (we_ctrl_i)   ctrl_d   = wdata_i[CTRL_W-1:0];
        if (we_period_i) period_d = wdata_i;
        if (we_status_i && wdata_i[STATUS_PEND_BIT]) pend_d = 1'b0;
        if (match) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q    <= '0;
            ctrl_q   <= '0;
            period_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            pend_q   <= pend_d;
        end
    end

    assign cmp_o     = cmp_q;
    assign ctrl_o    = ctrl_q;
    assign period_o  = period_q;
    assign pend_o    = pend_q;
    assign irq_bit_o = pend_q && ctrl_q[IE_BIT];

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped multi-channel compare timer: shared counter, optional prescaler, decode, read mux.
// Optional prescaler is built when TIMER_BANK_PRESCALE_EN is defined.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              io_hit,
    output logic [31:0]       rd_data,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [31:0] WIN_BYTES = 32'(CH_BASE + CH_STRIDE * NUM_CH);

    logic [31:0] off;
    logic [27:0] blk;
    logic [3:0]  woff;
    logic        wr_en;
    logic        tick;
    logic [31:0] pre_rd;
    logic        unused_bits;

    // Out-of-window addresses below BASE wrap to huge offsets, so one compare covers both ends.
    assign off    = addr - BASE_ADDR;
    assign io_hit = off < WIN_BYTES;
    assign blk    = off[31:4];
    assign woff   = {off[3:2], 2'b00};
    assign wr_en  = mem_write && io_hit;
    assign unused_bits = ^{off[1:0], wr_data};

    logic [CNT_W-1:0] count_q, count_d;

    assign count_d = tick ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

`ifdef TIMER_BANK_PRESCALE_EN
    logic [CNT_W-1:0] pre_q, pre_d, div_q, div_d;
    logic             we_pre;

    assign we_pre = wr_en && (blk == '0) && (woff == OFF_PRESCALE);
    assign tick   = (div_q == pre_q);
    assign pre_rd = 32'(pre_q);

    always_comb begin
        pre_d = pre_q;
        div_d = tick ? '0 : div_q + CNT_W'(1);
        if (we_pre) begin
            pre_d = wr_data[CNT_W-1:0];
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            div_q <= '0;
        end else begin
            pre_q <= pre_d;
            div_q <= div_d;
        end
    end
`else
    assign tick   = 1'b1;
    assign pre_rd = '0;
`endif

    logic [NUM_CH-1:0][CNT_W-1:0]  ch_cmp, ch_period;
    logic [NUM_CH-1:0][CTRL_W-1:0] ch_ctrl;
    logic [NUM_CH-1:0]             ch_pend;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && (blk == 28'(i + 1));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (reset),
            .count_i     (count_q),
            .tick_i      (tick),
            .we_cmp_i    (sel && (woff == OFF_CMP)),
            .we_ctrl_i   (sel && (woff == OFF_CTRL)),
            .we_period_i (sel && (woff == OFF_PERIOD)),
            .we_status_i (sel && (woff == OFF_STATUS)),
            .wdata_i     (wr_data[CNT_W-1:0]),
            .cmp_o       (ch_cmp[i]),
            .ctrl_o      (ch_ctrl[i]),
            .period_o    (ch_period[i]),
            .pend_o      (ch_pend[i]),
            .irq_bit_o   (irq_vec[i])
        );
    end

    assign irq = |irq_vec;

    always_comb begin
        rd_data = '0;
        if (mem_read && io_hit) begin
            if (blk == '0) begin
                case (woff)
                    OFF_COUNT:    rd_data = 32'(count_q);
                    OFF_PRESCALE: rd_data = pre_rd;
                    default:      rd_data = '0;
                endcase
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (blk == 28'(i + 1)) begin
                    case (woff)
                        OFF_CMP:    rd_data = 32'(ch_cmp[i]);
                        OFF_CTRL:   rd_data = 32'(ch_ctrl[i]);
                        OFF_PERIOD: rd_data = 32'(ch_period[i]);
                        default:    rd_data[STATUS_PEND_BIT] = ch_pend[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank (NUM_CH=4, CNT_W=8): directed scenarios plus random bus traffic vs a reference model.
module tb_timer_bank;

    localparam int          NCH  = 4;
    localparam int          CW   = 8;
    localparam int          MASK = (1 << CW) - 1;
    localparam logic [31:0] BASE = 32'hFFFF0100;
`ifdef TIMER_BANK_PRESCALE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [31:0]    addr = '0;
    logic [31:0]    wr_data = '0;
    logic           mem_read = 1'b0;
    logic           mem_write = 1'b0;
    logic           io_hit;
    logic [31:0]    rd_data;
    logic           irq;
    logic [NCH-1:0] irq_vec;

    timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
        .mem_read(mem_read), .mem_write(mem_write), .io_hit(io_hit),
        .rd_data(rd_data), .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model state: plain integers, one entry per channel.
    int m_cnt, m_pre, m_since;
    int m_cmp[NCH], m_ctrl[NCH], m_per[NCH];
    bit m_pend[NCH];

    // Sampled DUT outputs and model expectations for the last bus cycle.
    logic           s_hit, s_irq, e_hit, e_irq;
    logic [31:0]    s_rd, e_rd;
    logic [NCH-1:0] s_vec, e_vec;

    function automatic logic [31:0] ch_addr(input int ch, input int r);
        return BASE + 32'(16 * (ch + 1) + 4 * r);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        logic [63:0] ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, BASE};
        return (ua >= ub) && (ua < ub + 64'(16 * (NCH + 1)));
    endfunction

    function automatic int m_read(input logic [31:0] a);
        int off, blk, r;
        off = int'(a - BASE);
        blk = off / 16;
        r = (off % 16) / 4;
        if (blk == 0) return (r == 0) ? m_cnt : (r == 1) ? m_pre : 0;
        case (r)
            0: return m_cmp[blk-1];
            1: return m_ctrl[blk-1];
            2: return m_per[blk-1];
            default: return m_pend[blk-1] ? 1 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_since = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_cmp[ch] = 0; m_ctrl[ch] = 0; m_per[ch] = 0; m_pend[ch] = 0;
        end
    endtask

    task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit tk;
        bit mt[NCH];
        int off, blk, r, ch;
        // A tick lands on the last cycle of each (PRESCALE+1)-cycle window since the last PRESCALE write.
        tk = (m_since % (m_pre + 1)) == m_pre;
        for (int c = 0; c < NCH; c++) begin
            mt[c] = tk && ((m_ctrl[c] & 1) != 0) && (m_cnt == m_cmp[c]);
            if (mt[c]) begin
                m_pend[c] = 1;
                if ((m_ctrl[c] & 2) != 0) m_cmp[c] = (m_cmp[c] + m_per[c]) & MASK;
                else m_ctrl[c] = m_ctrl[c] & 6;
            end
        end
        if (tk) m_cnt = (m_cnt + 1) & MASK;
        m_since++;
        if (we && m_hit(a)) begin
            off = int'(a - BASE);
            blk = off / 16;
            r = (off % 16) / 4;
            if (blk == 0) begin
                if (r == 1 && PRE_EN) begin
                    m_pre = int'(d) & MASK;
                    m_since = 0;
                end
            end else begin
                ch = blk - 1;
                case (r)
                    0: m_cmp[ch] = int'(d) & MASK;
                    1: m_ctrl[ch] = int'(d) & 7;
                    2: m_per[ch] = int'(d) & MASK;
                    default: if (d[0] && !mt[ch]) m_pend[ch] = 0;
                endcase
            end
        end
    endtask

    // One bus cycle: drive just after the edge, sample mid-cycle, advance the model, cross the edge.
    task automatic bus(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        mem_write = we; mem_read = re; addr = a; wr_data = d;
        #4;
        s_hit = io_hit; s_rd = rd_data; s_irq = irq; s_vec = irq_vec;
        e_hit = m_hit(a);
        e_rd = (re && e_hit) ? 32'(m_read(a)) : 32'd0;
        for (int ch = 0; ch < NCH; ch++) e_vec[ch] = m_pend[ch] && ((m_ctrl[ch] & 4) != 0);
        e_irq = |e_vec;
        model_step(we, a, d);
        @(posedge clk);
        #1;
        cyc++;
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        addr = BASE; mem_read = 1'b1;
        #12;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_total++; if (irq_vec !== '0) $display("FAIL reset_vec: got %b want 0", irq_vec); else n_pass++;
        n_total++; if (rd_data !== 32'd0) $display("FAIL reset_rd: got %h want 0", rd_data); else n_pass++;
        addr = BASE + 32'h4C;
        #1;
        n_total++; if (io_hit !== 1'b1) $display("FAIL reset_hit: got %b want 1", io_hit); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        bus(0, 1, BASE, 0);
        c0 = int'(s_rd);
        n_total++; if (s_rd !== 32'd0) $display("FAIL count_start: got %0d want 0", s_rd); else n_pass++;
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(0, 1, BASE, 0);
        n_total++; if (int'(s_rd) - c0 !== 3) $display("FAIL count_delta: got %0d want 3", int'(s_rd) - c0); else n_pass++;
        bus(0, 1, BASE + 32'h4C, 0);
        n_total++; if (s_hit !== 1'b1) $display("FAIL hit_last: got %b want 1", s_hit); else n_pass++;
        bus(0, 1, BASE + 32'h50, 0);
        n_total++; if (s_hit !== 1'b0 || s_rd !== 32'd0) $display("FAIL hit_past: got %b/%h want 0/0", s_hit, s_rd); else n_pass++;
        bus(0, 1, BASE - 32'd4, 0);
        n_total++; if (s_hit !== 1'b0 || s_irq !== 1'b0) $display("FAIL hit_below: got %b irq %b want 0 0", s_hit, s_irq); else n_pass++;
    endtask

    task automatic test_oneshot();
        int c, k;
        bit found, again;
        bus(0, 1, BASE, 0);
        c = int'(s_rd);
        bus(1, 0, ch_addr(0, 0), 32'((c + 10) & MASK));
        bus(1, 0, ch_addr(0, 1), 32'd5);
        found = 0;
        for (k = 0; k < 40 && !found; k++) begin
            bus(0, 1, BASE, 0);
            if (s_irq) found = 1;
        end
        n_total++; if (!found) $display("FAIL oneshot_timeout: got no irq want irq"); else n_pass++;
        n_total++; if (s_rd !== 32'((c + 11) & MASK)) $display("FAIL oneshot_edge: got count %0d want %0d", s_rd, (c + 11) & MASK); else n_pass++;
        bus(0, 1, ch_addr(0, 1), 0);
        n_total++; if (s_rd !== 32'd4) $display("FAIL oneshot_ctrl: got %0d want 4", s_rd); else n_pass++;
        bus(1, 0, ch_addr(0, 3), 32'd1);
        bus(0, 0, BASE, 0);
        n_total++; if (s_irq !== 1'b0) $display("FAIL oneshot_clear: got %b want 0", s_irq); else n_pass++;
        again = 0;
        for (int i = 0; i < 300; i++) begin
            bus(0, 0, BASE, 0);
            if (s_irq) again = 1;
        end
        n_total++; if (again) $display("FAIL oneshot_recur: got 1 want 0"); else n_pass++;
    endtask

    task automatic test_periodic();
        int c, fires, last;
        bus(0, 1, BASE, 0);
        c = int'(s_rd);
        bus(1, 0, ch_addr(2, 2), 32'd5);
        bus(1, 0, ch_addr(2, 0), 32'((c + 8) & MASK));
        bus(1, 0, ch_addr(2, 1), 32'd7);
        fires = 0;
        last = -1;
        for (int k = 0; k < 60 && fires < 4; k++) begin
            bus(0, 1, ch_addr(2, 3), 0);
            if (s_rd[0]) begin
                if (last >= 0) begin
                    n_total++; if (cyc - last !== 5) $display("FAIL periodic_gap: got %0d want 5", cyc - last); else n_pass++;
                end
                last = cyc;
                fires++;
                bus(1, 0, ch_addr(2, 3), 32'd1);
            end
        end
        n_total++; if (fires !== 4) $display("FAIL periodic_fires: got %0d want 4", fires); else n_pass++;
        bus(0, 1, ch_addr(2, 0), 0);
        n_total++; if (s_rd !== 32'((c + 8 + 20) & MASK)) $display("FAIL periodic_cmp: got %0d want %0d", s_rd, (c + 28) & MASK); else n_pass++;
        bus(1, 0, ch_addr(2, 1), 32'd0);
        bus(1, 0, ch_addr(2, 3), 32'd1);
    endtask

    task automatic test_wrap();
        int k, first, cnt_at;
        bit got;
        got = 0;
        for (k = 0; k < 300 && !got; k++) begin
            bus(0, 1, BASE, 0);
            if (s_rd == 32'hFB) got = 1;
        end
        n_total++; if (!got) $display("FAIL wrap_poll: got timeout want count 0xFB"); else n_pass++;
        bus(1, 0, ch_addr(1, 0), 32'h80);
        bus(1, 0, ch_addr(1, 1), 32'd5);
        bus(1, 0, ch_addr(1, 0), 32'h02);
        first = -1;
        cnt_at = -1;
        for (k = 1; k <= 10; k++) begin
            bus(0, 1, BASE, 0);
            if (s_vec[1] && first < 0) begin
                first = k;
                cnt_at = int'(s_rd);
            end
        end
        n_total++; if (first !== 5) $display("FAIL wrap_delay: got %0d want 5", first); else n_pass++;
        n_total++; if (cnt_at !== 3) $display("FAIL wrap_count: got %0d want 3", cnt_at); else n_pass++;
        bus(1, 0, ch_addr(1, 3), 32'd1);
    endtask

    task automatic test_collision();
        int c;
        bus(0, 1, BASE, 0);
        c = int'(s_rd);
        bus(1, 0, ch_addr(3, 0), 32'((c + 6) & MASK));
        bus(1, 0, ch_addr(3, 1), 32'd5);
        bus(0, 1, BASE, 0);
        n_total++; if (s_rd !== 32'((c + 3) & MASK)) $display("FAIL coll_count: got %0d want %0d", s_rd, (c + 3) & MASK); else n_pass++;
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(1, 0, ch_addr(3, 3), 32'd1);
        bus(0, 1, ch_addr(3, 3), 0);
        n_total++; if (s_rd !== 32'd1) $display("FAIL coll_pend: got %0d want 1", s_rd); else n_pass++;
        n_total++; if (s_vec[3] !== 1'b1) $display("FAIL coll_vec3: got %b want 1", s_vec[3]); else n_pass++;
        // ch0 fires with interrupts disabled
        bus(0, 1, BASE, 0);
        c = int'(s_rd);
        bus(1, 0, ch_addr(0, 0), 32'((c + 4) & MASK));
        bus(1, 0, ch_addr(0, 1), 32'd1);
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(0, 1, ch_addr(0, 3), 0);
        n_total++; if (s_rd !== 32'd1) $display("FAIL ie0_status: got %0d want 1", s_rd); else n_pass++;
        n_total++; if (s_vec[0] !== 1'b0) $display("FAIL ie0_vec: got %b want 0", s_vec[0]); else n_pass++;
        // enabling on the matching cycle must not fire
        bus(1, 0, ch_addr(0, 3), 32'd1);
        bus(0, 1, BASE, 0);
        c = int'(s_rd);
        bus(1, 0, ch_addr(0, 0), 32'((c + 3) & MASK));
        bus(0, 0, BASE, 0);
        bus(1, 0, ch_addr(0, 1), 32'd5);
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(0, 1, ch_addr(0, 3), 0);
        n_total++; if (s_rd !== 32'd0) $display("FAIL en_same_cycle: got %0d want 0", s_rd); else n_pass++;
        bus(0, 1, ch_addr(0, 1), 0);
        n_total++; if (s_rd !== 32'd5) $display("FAIL en_same_ctrl: got %0d want 5", s_rd); else n_pass++;
        bus(1, 0, ch_addr(0, 1), 32'd0);
    endtask

    task automatic test_async_reset();
        bus(0, 0, BASE, 0);
        n_total++; if (s_irq !== 1'b1) $display("FAIL areset_pre: got %b want 1", s_irq); else n_pass++;
        addr = BASE; mem_read = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (irq !== 1'b0 || irq_vec !== '0) $display("FAIL areset_irq: got %b/%b want 0/0", irq, irq_vec); else n_pass++;
        n_total++; if (rd_data !== 32'd0) $display("FAIL areset_count: got %0d want 0", rd_data); else n_pass++;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        bus(0, 1, ch_addr(3, 3), 0);
        n_total++; if (s_rd !== 32'd0) $display("FAIL areset_pend: got %0d want 0", s_rd); else n_pass++;
    endtask

    task automatic test_prescale();
        int a, b;
`ifdef TIMER_BANK_PRESCALE_EN
        int seen;
        bus(1, 0, BASE + 32'h4, 32'd3);
        bus(0, 1, BASE, 0);
        a = int'(s_rd);
        for (int k = 0; k < 15; k++) bus(0, 0, BASE, 0);
        bus(0, 1, BASE, 0);
        b = int'(s_rd);
        n_total++; if (((b - a) & MASK) !== 4) $display("FAIL pre_rate: got %0d want 4", (b - a) & MASK); else n_pass++;
        bus(0, 1, BASE + 32'h4, 0);
        n_total++; if (s_rd !== 32'd3) $display("FAIL pre_read: got %0d want 3", s_rd); else n_pass++;
        bus(1, 0, ch_addr(1, 2), 32'd0);
        bus(1, 0, ch_addr(1, 0), 32'((b + 2) & MASK));
        bus(1, 0, ch_addr(1, 1), 32'd7);
        seen = 0;
        for (int k = 0; k < 48; k++) begin
            bus(0, 1, ch_addr(1, 3), 0);
            if (s_rd[0]) begin
                seen++;
                bus(1, 0, ch_addr(1, 3), 32'd1);
            end
        end
        n_total++; if (seen !== 1) $display("FAIL pre_once: got %0d fires want 1", seen); else n_pass++;
        bus(1, 0, ch_addr(1, 1), 32'd0);
        bus(1, 0, BASE + 32'h4, 32'd0);
`else
        bus(1, 0, BASE + 32'h4, 32'd3);
        bus(0, 1, BASE + 32'h4, 0);
        n_total++; if (s_rd !== 32'd0) $display("FAIL pre_off_read: got %0d want 0", s_rd); else n_pass++;
        bus(0, 1, BASE, 0);
        a = int'(s_rd);
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(0, 0, BASE, 0);
        bus(0, 1, BASE, 0);
        b = int'(s_rd);
        n_total++; if (((b - a) & MASK) !== 4) $display("FAIL pre_off_rate: got %0d want 4", (b - a) & MASK); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int sel, op, blk, r;
        logic [31:0] a, d;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 19));
            blk = -1;
            r = 0;
            if (sel == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (sel == 1) a = BASE + 32'h50 + 32'($urandom_range(0, 60));
            else begin
                blk = int'($urandom_range(0, NCH));
                r = int'($urandom_range(0, 3));
                a = BASE + 32'(16 * blk + 4 * r) + 32'($urandom_range(0, 3));
            end
            d = $urandom;
            if (blk == 0 && r == 1) d = 32'($urandom_range(0, 2));
            else if (blk > 0 && r == 0) d = (d & 32'hFFFFFF00) | 32'((m_cnt + int'($urandom_range(0, 8))) & MASK);
            else if (blk > 0 && r == 2) d = 32'($urandom_range(0, 7));
            op = int'($urandom_range(0, 9));
            bus(op >= 4 && op <= 8, op <= 3 || op == 8, a, d);
            n_total++; if (s_hit !== e_hit) $display("FAIL rnd_hit: a=%h got %b want %b", a, s_hit, e_hit); else n_pass++;
            n_total++; if (s_rd !== e_rd) $display("FAIL rnd_rd: a=%h got %h want %h", a, s_rd, e_rd); else n_pass++;
            n_total++; if (s_vec !== e_vec) $display("FAIL rnd_vec: got %b want %b", s_vec, e_vec); else n_pass++;
            n_total++; if (s_irq !== e_irq) $display("FAIL rnd_irq: got %b want %b", s_irq, e_irq); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_collision();
        test_async_reset();
        test_prescale();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
